// File: rtl/pipe_store_unit_pkg.sv
// Shared encodings for the MEM-stage store path: store op codes, FSM states
// and the lane-mirroring helper used for big-endian byte enables.
package pipe_store_unit_pkg;

   typedef enum logic [1:0] {
      ST_BYTE = 2'b00,
      ST_HALF = 2'b01,
      ST_WORD = 2'b10,
      ST_RSVD = 2'b11
   } st_op_e;

   typedef enum logic {
      SU_IDLE = 1'b0,
      SU_REQ  = 1'b1
   } su_state_e;

   function automatic logic [3:0] be_mirror(input logic [3:0] be);
      return {be[0], be[1], be[2], be[3]};
   endfunction

endpackage

// File: rtl/pipe_store_unit_lane.sv
// Combinational store narrowing: byte enables, lane-replicated write data and
// misalignment detection from the store op and the low address bits.
module pipe_store_lane
   import pipe_store_unit_pkg::*;
#(
   parameter int BIG_ENDIAN = 0
) (
   input  logic [1:0]  i_op,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   output logic        o_rsvd
);

   logic [3:0] w_be_le;

   always_comb begin
      w_be_le      = 4'b0000;
      o_wdata      = i_data;
      o_misaligned = 1'b0;
      case (i_op)
         ST_BYTE: begin
            w_be_le = 4'b0001 << i_addr;
            o_wdata = {4{i_data[7:0]}};
         end
         ST_HALF: begin
            w_be_le      = i_addr[1] ? 4'b1100 : 4'b0011;
            o_wdata      = {2{i_data[15:0]}};
            o_misaligned = i_addr[0];
         end
         ST_WORD: begin
            w_be_le      = 4'b1111;
            o_misaligned = |i_addr;
         end
         default: begin
            w_be_le = 4'b0000;
         end
      endcase
   end

   // Replicated data already serves both lane orders; only enables mirror.
   assign o_be   = (BIG_ENDIAN != 0) ? be_mirror(w_be_le) : w_be_le;
   assign o_rsvd = (i_op == ST_RSVD);

endmodule

// File: rtl/pipe_store_unit.sv
// MEM-stage store unit: one outstanding data-memory write under req/ack,
// AdES reporting for misaligned stores and a watchdog raising bus_err.
module pipe_store_unit
   import pipe_store_unit_pkg::*;
#(
   parameter int BIG_ENDIAN     = 0,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid,
   input  logic [1:0]  st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_ready,
   output logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic        ades,
   output logic        bus_err,
   output logic [31:0] badvaddr
);

   localparam bit               LP_WD_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   su_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]      r_addr, r_wdata, r_badv;
   logic [3:0]       r_be;
   logic             r_ades, r_berr;

   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic             w_mis, w_rsvd;
   logic             w_ack_req, w_accept, w_issue, w_fault, w_expire;

   pipe_store_lane #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane (
      .i_op         (st_op),
      .i_addr       (st_addr[1:0]),
      .i_data       (st_data),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (w_mis),
      .o_rsvd       (w_rsvd)
   );

   // An ack only counts while a request is actually on the bus.
   assign w_ack_req = (r_state == SU_REQ) & mem_ack;
   assign st_ready  = (r_state == SU_IDLE) | w_ack_req;
   assign stall     = st_valid & ~st_ready;
   assign w_accept  = st_valid & st_ready;
   assign w_issue   = w_accept & ~w_rsvd & ~w_mis;
   assign w_fault   = w_accept & ~w_rsvd & w_mis;
   assign w_expire  = LP_WD_EN & (r_state == SU_REQ) & ~mem_ack & (r_cnt == LP_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         SU_IDLE: begin
            if (w_issue) begin
               w_state_nxt = SU_REQ;
               w_cnt_nxt   = '0;
            end
         end
         SU_REQ: begin
            if (mem_ack) begin
               w_state_nxt = w_issue ? SU_REQ : SU_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_expire) begin
               w_state_nxt = SU_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = SU_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= SU_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_ades  <= 1'b0;
         r_berr  <= 1'b0;
         r_badv  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ades  <= w_fault;
         r_berr  <= w_expire;
         if (w_issue) begin
            r_addr  <= {st_addr[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
         end
         if (w_fault) begin
            r_badv <= st_addr;
         end
      end
   end

   assign mem_req   = (r_state == SU_REQ);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_be    = r_be;
   assign ades      = r_ades;
   assign bus_err   = r_berr;
   assign badvaddr  = r_badv;

endmodule

// File: tb/tb_pipe_store_unit.sv
// Bench for pipe_store_unit: little- and big-endian instances driven in
// parallel, directed scenarios followed by randomized traffic.
module tb_pipe_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [1:0]  st_op;
   logic [31:0] st_addr, st_data;
   logic        mem_ack;

   logic        st_ready, stall, mem_req, ades, bus_err;
   logic [31:0] mem_addr, mem_wdata, badvaddr;
   logic [3:0]  mem_be;
   logic        b_st_ready, b_stall, b_mem_req, b_ades, b_bus_err;
   logic [31:0] b_mem_addr, b_mem_wdata, b_badvaddr;
   logic [3:0]  b_mem_be;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_store_unit #(.BIG_ENDIAN(0), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_op(st_op),
      .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready), .stall(stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .ades(ades), .bus_err(bus_err),
      .badvaddr(badvaddr)
   );

   pipe_store_unit #(.BIG_ENDIAN(1), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut_be (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_op(st_op),
      .st_addr(st_addr), .st_data(st_data), .st_ready(b_st_ready), .stall(b_stall),
      .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_be(b_mem_be), .mem_ack(mem_ack), .ades(b_ades), .bus_err(b_bus_err),
      .badvaddr(b_badvaddr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   // Reference rules written from the byte-lane description.
   function automatic logic [3:0] ref_be_le(input logic [1:0] op, input logic [31:0] a);
      logic [3:0] m;
      m = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (op == 2'd0 && i == int'(a[1:0])) m[i] = 1'b1;
         if (op == 2'd1 && (i / 2) == int'(a[1])) m[i] = 1'b1;
         if (op == 2'd2) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [3:0] ref_mirror(input logic [3:0] m);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[3 - i] = m[i];
      return r;
   endfunction

   function automatic logic [31:0] ref_wd(input logic [1:0] op, input logic [31:0] d);
      if (op == 2'd0) return d[7:0] * 32'h01010101;
      if (op == 2'd1) return d[15:0] * 32'h00010001;
      return d;
   endfunction

   function automatic bit ref_mis(input logic [1:0] op, input logic [31:0] a);
      return (op == 2'd1 && a[0]) || (op == 2'd2 && a[1:0] != 2'b00);
   endfunction

   bit          m_on = 0;
   bit          m_busy, m_ades, m_berr, m_zero, m_acc;
   int          m_wait;
   logic [31:0] m_addr, m_wd, m_badv;
   logic [3:0]  m_be_le;

   always @(negedge clk) begin
      if (m_on) begin
         chk("ready",   st_ready,   !m_busy || mem_ack);
         chk("b_ready", b_st_ready, !m_busy || mem_ack);
         chk("stall",   stall,      st_valid && m_busy && !mem_ack);
         chk("b_stall", b_stall,    st_valid && m_busy && !mem_ack);
         chk("mem_req",   mem_req,   m_busy);
         chk("b_mem_req", b_mem_req, m_busy);
         if (m_busy || m_zero) begin
            chk("mem_addr",    mem_addr,    m_addr);
            chk("mem_wdata",   mem_wdata,   m_wd);
            chk("mem_be",      mem_be,      m_be_le);
            chk("b_mem_addr",  b_mem_addr,  m_addr);
            chk("b_mem_wdata", b_mem_wdata, m_wd);
            chk("b_mem_be",    b_mem_be,    ref_mirror(m_be_le));
         end
         chk("ades",      ades,      m_ades);
         chk("bus_err",   bus_err,   m_berr);
         chk("b_ades",    b_ades,    m_ades);
         chk("b_bus_err", b_bus_err, m_berr);
         if (m_ades || m_zero) begin
            chk("badvaddr",   badvaddr,   m_badv);
            chk("b_badvaddr", b_badvaddr, m_badv);
         end
         chk("ades_excl", ades & bus_err, 0);
      end
      if (rst === 1'b0) begin
         m_on = 1; m_busy = 0; m_wait = 0; m_addr = 0; m_wd = 0; m_be_le = 0;
         m_ades = 0; m_berr = 0; m_badv = 0; m_zero = 1;
      end else if (m_on) begin
         m_acc  = st_valid && (!m_busy || mem_ack);
         m_ades = 0;
         m_berr = 0;
         if (m_busy) begin
            if (mem_ack) begin
               m_busy = 0;
               m_wait = 0;
            end else begin
               m_wait++;
               if (TO != 0 && m_wait >= TO) begin
                  m_busy = 0;
                  m_berr = 1;
                  m_wait = 0;
               end
            end
         end
         if (m_acc && st_op != 2'b11) begin
            m_zero = 0;
            if (ref_mis(st_op, st_addr)) begin
               m_ades = 1;
               m_badv = st_addr;
            end else begin
               m_busy  = 1;
               m_wait  = 0;
               m_addr  = {st_addr[31:2], 2'b00};
               m_wd    = ref_wd(st_op, st_data);
               m_be_le = ref_be_le(st_op, st_addr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drv(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
      st_valid = v; st_op = op; st_addr = a; st_data = d;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_req"},   mem_req,   0);
      chk({nm, "_addr"},  mem_addr,  0);
      chk({nm, "_wdata"}, mem_wdata, 0);
      chk({nm, "_be"},    mem_be,    0);
      chk({nm, "_ades"},  ades,      0);
      chk({nm, "_berr"},  bus_err,   0);
      chk({nm, "_badv"},  badvaddr,  0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, actual=running required=done");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst = 1'b0; mem_ack = 1'b0;
      drv(0, 2'b00, 32'h0, 32'h0);
      tick(); tick();
      smp();
      chk_zero("rst");
      chk("rst_ready", st_ready, 1);

      // sb 0x1003
      tick(); rst = 1'b1; drv(1, 2'b00, 32'h0000_1003, 32'h0000_00A5);
      smp(); chk("sb_ready", st_ready, 1); chk("sb_stall", stall, 0);
      tick(); drv(0, 2'b00, 32'h0, 32'h0);
      smp();
      chk("sb_req", mem_req, 1); chk("sb_addr", mem_addr, 32'h0000_1000);
      chk("sb_be", mem_be, 4'b1000); chk("sb_be_big", b_mem_be, 4'b0001);
      chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      tick(); mem_ack = 1'b1;
      smp();
      tick(); mem_ack = 1'b0; drv(1, 2'b01, 32'h0000_2002, 32'h1234_BEEF);

      // sh with delayed ack, sw queued behind it
      smp(); chk("sh_ready", st_ready, 1);
      tick(); drv(1, 2'b10, 32'h0000_2100, 32'hCAFE_F00D);
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("sh_stall", stall, 1); chk("sh_req", mem_req, 1);
         chk("sh_addr", mem_addr, 32'h0000_2000); chk("sh_be", mem_be, 4'b1100);
         chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
         tick();
      end
      mem_ack = 1'b1;
      smp(); chk("sh_ack_stall", stall, 0); chk("sh_ack_ready", st_ready, 1);
      tick(); drv(0, 2'b00, 32'h0, 32'h0);
      smp();
      chk("b2b_req", mem_req, 1); chk("b2b_addr", mem_addr, 32'h0000_2100);
      chk("b2b_be", mem_be, 4'b1111); chk("b2b_wdata", mem_wdata, 32'hCAFE_F00D);
      tick(); mem_ack = 1'b0; drv(1, 2'b10, 32'h0000_3001, 32'h1111_2222);

      // misaligned sw
      smp(); chk("ades_stall", stall, 0); chk("ades_ready", st_ready, 1);
      tick(); drv(0, 2'b00, 32'h0, 32'h0);
      smp(); chk("ades_req", mem_req, 0); chk("ades_hi", ades, 1);
      chk("ades_badv", badvaddr, 32'h0000_3001);
      tick(); smp(); chk("ades_lo", ades, 0);

      // watchdog expiry
      tick(); drv(1, 2'b10, 32'h0000_4000, 32'h4444_4444);
      smp();
      tick(); drv(0, 2'b00, 32'h0, 32'h0);
      for (int i = 0; i < TO; i++) begin
         smp(); chk("wd_req", mem_req, 1); chk("wd_berr", bus_err, 0);
         tick();
      end
      smp(); chk("wd_req_drop", mem_req, 0); chk("wd_berr_hi", bus_err, 1);
      tick(); smp(); chk("wd_berr_lo", bus_err, 0);

      // ack in the expiry cycle wins
      tick(); drv(1, 2'b10, 32'h0000_5000, 32'h5555_5555);
      smp();
      tick(); drv(0, 2'b00, 32'h0, 32'h0);
      for (int i = 0; i < TO - 1; i++) begin
         smp(); chk("wd2_req", mem_req, 1);
         tick();
      end
      mem_ack = 1'b1;
      smp(); chk("wd2_req_last", mem_req, 1);
      tick(); mem_ack = 1'b0;
      smp(); chk("wd2_berr", bus_err, 0); chk("wd2_req_done", mem_req, 0);

      // reset in the second REQ cycle
      tick(); drv(1, 2'b00, 32'h0000_6000, 32'h0000_0077);
      smp();
      tick(); drv(0, 2'b00, 32'h0, 32'h0);
      smp(); chk("mrst_req1", mem_req, 1);
      tick(); rst = 1'b0;
      smp(); chk("mrst_req2", mem_req, 1);
      tick(); rst = 1'b1;
      smp(); chk_zero("mrst");
      tick(); drv(1, 2'b00, 32'h0000_6001, 32'h0000_005A);
      smp();
      tick(); drv(0, 2'b00, 32'h0, 32'h0);
      smp();
      chk("post_req", mem_req, 1); chk("post_be", mem_be, 4'b0010);
      chk("post_be_big", b_mem_be, 4'b0100); chk("post_wdata", mem_wdata, 32'h5A5A_5A5A);
      tick(); mem_ack = 1'b1;
      smp();
      tick(); mem_ack = 1'b0; drv(1, 2'b11, 32'h0000_7002, 32'h7777_7777);

      // reserved op
      smp(); chk("rsvd_ready", st_ready, 1); chk("rsvd_stall", stall, 0);
      tick(); drv(0, 2'b00, 32'h0, 32'h0);
      smp(); chk("rsvd_req", mem_req, 0); chk("rsvd_ades", ades, 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst      = ($urandom_range(0, 99) != 0);
         mem_ack  = ($urandom_range(0, 2) == 0);
         drv($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom);
      end
      tick();
      drv(0, 2'b00, 32'h0, 32'h0);
      smp();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_store_unit.md
Name: pipe_store_unit

Overview:
- MEM-stage store path; the narrowing counterpart of the immediate/load extenders.
- Takes a 32-bit rt value plus a byte/half/word store op from the EX/MEM register.
- Produces a word-aligned data-memory write with replicated lane data and byte enables, and reports misaligned stores (AdES).
- Holds a single outstanding request under a req/ack handshake, with a watchdog timeout, and stalls the pipeline while busy.

Parameters:
- BIG_ENDIAN, 0, 0 = little-endian lane mapping; 1 = mirrored lanes (byte k maps to lane 3-k).
- TIMEOUT_CYCLES, 255, maximum REQ cycles without mem_ack before bus error; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- st_valid  input  1  store request from EX/MEM.
- st_op  input  2  store op: `ST_BYTE, `ST_HALF, `ST_WORD; 2'b11 is reserved.
- st_addr  input  32  effective byte address.
- st_data  input  32  rt register value.
- st_ready  output  1  request accepted this cycle (combinational).
- stall  output  1  equals st_valid & ~st_ready.
- mem_req  output  1  write request to data memory.
- mem_addr  output  32  {st_addr[31:2], 2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables, bit i enables byte lane i (bits [8i+7:8i]).
- mem_ack  input  1  memory accepted the write.
- ades  output  1  one-cycle pulse: misaligned store.
- bus_err  output  1  one-cycle pulse: watchdog expired.
- badvaddr  output  32  faulting st_addr, valid while ades is high.

Behaviour:
- States: IDLE and REQ.
- Reset (rst=0 at an edge): state IDLE; mem_req, mem_addr, mem_wdata, mem_be, ades, bus_err, badvaddr and the counter all 0.
- Reset mid-REQ: mem_req drops on the same edge; the request is abandoned and no error is raised.
- Acceptance: st_ready = (state==IDLE) | (state==REQ & mem_ack).
- An accepted aligned store loads the output registers; mem_req=1 from the next cycle (latency 1).
- mem_addr, mem_wdata and mem_be stay stable while mem_req=1 and no mem_ack.
- A request completes in the cycle mem_ack=1 while mem_req=1.
  - If another store is accepted that same cycle, mem_req stays 1 and the fields update at the edge (back-to-back, no bubble).
  - Otherwise state goes to IDLE and mem_req=0.
- mem_ack while mem_req=0 is ignored.
- Lane rules, little-endian, k = st_addr[1:0]:
  - byte: be = 1<<k; wdata = {4{st_data[7:0]}}.
  - half: addr[1]=0 gives be 4'b0011, addr[1]=1 gives be 4'b1100; wdata = {2{st_data[15:0]}}.
  - word: be 4'b1111; wdata = st_data.
- BIG_ENDIAN=1: mem_be bit-reversed; wdata unchanged, since replication already covers both mappings.
- Misalignment (half with addr[0]=1; word with addr[1:0]!=0): the store is accepted but issues no mem_req. Next cycle ades=1 and badvaddr=st_addr; state follows the normal completion rule.
- Reserved op 2'b11: accepted, no request, no exception.
- Watchdog:
  - Counter clears on entering REQ and on each completion.
  - It increments on every REQ cycle without mem_ack.
  - If count == TIMEOUT_CYCLES-1 and mem_ack=0: next cycle mem_req=0, bus_err=1 for one cycle, state IDLE.
  - mem_ack in the expiry cycle wins: normal completion, no bus_err.
- ades and bus_err are never high together.

Decomposition:
- ctrl_encode_def.v gains `ST_BYTE 2'b00, `ST_HALF 2'b01, `ST_WORD 2'b10 and the state encodings `SU_IDLE and `SU_REQ.
- Sub-module pipe_store_lane: purely combinational (st_op, addr[1:0], st_data, BIG_ENDIAN) → (be, wdata, misaligned).
- The top module holds the FSM, the watchdog counter and the output registers.

Test Plan:
- Reset, then sb with addr=0x1003, data=0xA5: one cycle later mem_req=1, mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xA5A5A5A5. BIG_ENDIAN=1 gives be=4'b0001.
- sh with addr=0x2002, data=0x1234BEEF, ack after 3 cycles: be=4'b1100, wdata=0xBEEFBEEF; stall=1 for 3 cycles with fields stable; a second sw is accepted in the ack cycle and mem_req never drops.
- sw with addr=0x3001: no mem_req; next cycle ades=1 and badvaddr=0x3001 for exactly one cycle; stall=0.
- TIMEOUT_CYCLES=4, sw with no ack: mem_req high 4 cycles, then bus_err=1 for one cycle and mem_req=0. Repeat with ack in the 4th cycle: no bus_err.
- rst=0 in the 2nd REQ cycle: after that edge all outputs are 0; after release a new sb issues normally.
- op=2'b11 with st_valid=1: st_ready=1, no mem_req, no ades.
